uart_rx_frame_ctrl: RTL and testbench

//  UART RX frame controller. Detects the start bit, runs the per-bit oversampling

---
 rtl/uart_rx_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : UART RX frame controller. Handles start detection, oversampled bit
//            timing, LSB-first deserialisation, parity and stop checking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int PRESCALER_WIDTH = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       rx_in,
  input  logic [PRESCALER_WIDTH-1:0] prescale,
  input  logic                       par_en,
  input  logic                       par_typ,
  input  logic                       sampled_bit,
  output logic                       dat_samp_en,
  output logic [PRESCALER_WIDTH-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]      p_data,
  output logic                       data_valid,
  output logic                       par_err,
  output logic                       stp_err,
  output logic                       busy
);

  localparam int                         CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALER_WIDTH-1:0] C_ONE      = PRESCALER_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0] C_MIN_P    = PRESCALER_WIDTH'(8);
  localparam logic [PRESCALER_WIDTH-1:0] C_MIN_LAST = PRESCALER_WIDTH'(7);
  localparam logic [CNT_W-1:0]           C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]           C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [PRESCALER_WIDTH-1:0]   r_edge_cnt;
  logic [PRESCALER_WIDTH-1:0]   r_last_edge;
  logic [CNT_W-1:0]             r_bit_cnt;
  logic [DATA_WIDTH-1:0]        r_shift;
  logic [DATA_WIDTH-1:0]        r_p_data;
  logic                         r_data_valid;
  logic                         r_par_err;
  logic                         r_stp_err;
  logic                         r_par_en;
  logic                         r_par_typ;

  logic [PRESCALER_WIDTH-1:0]   w_last_edge;
  logic                         w_start_det;
  logic                         w_bit_end;
  logic                         w_last_bit;
  logic                         w_par_exp;

  // The port cannot hold 2**PRESCALER_WIDTH, so 0 encodes the largest ratio
  // (all-ones last edge); other ratios below 8 run at 8.
  always_comb begin
    w_last_edge = prescale - C_ONE;
    if (prescale == '0) begin
      w_last_edge = '1;
    end else if (prescale < C_MIN_P) begin
      w_last_edge = C_MIN_LAST;
    end
  end

  always_comb begin
    w_start_det = (r_state == S_IDLE) && !rx_in;
    w_bit_end   = (r_state != S_IDLE) && (r_edge_cnt == r_last_edge);
    w_last_bit  = (r_bit_cnt == C_LAST_BIT);
    w_par_exp   = r_par_typ ? ~^r_shift : ^r_shift;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!rx_in) w_next = S_START;
      end
      S_START: begin
        if (w_bit_end) w_next = sampled_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt   <= '0;
      r_last_edge  <= C_MIN_LAST;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;

      if ((r_state == S_IDLE) || w_bit_end) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + C_ONE;
      end

      // Frame configuration is frozen at start detection.
      if (w_start_det) begin
        r_last_edge <= w_last_edge;
        r_par_en    <= par_en;
        r_par_typ   <= par_typ;
        r_par_err   <= 1'b0;
        r_stp_err   <= 1'b0;
      end

      if (w_bit_end) begin
        case (r_state)
          S_START: begin
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
          end
          S_PARITY: begin
            if (sampled_bit != w_par_exp) r_par_err <= 1'b1;
          end
          S_STOP: begin
            r_stp_err <= ~sampled_bit;
            if (sampled_bit && !r_par_err) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dat_samp_en = (r_state != S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign edge_cnt    = r_edge_cnt;
  assign p_data      = r_p_data;
  assign data_valid  = r_data_valid;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Self-checking bench for uart_rx_frame_ctrl: frame-level reference
//            model, per-cycle compare, word scoreboard and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = 5'd16;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          sampled_bit;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALER_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the majority-vote stage: the line value a few cycles back,
  // which lands mid-bit when the decision edge arrives.
  logic [7:0] hist = 8'hFF;
  always @(posedge CLK) hist <= {hist[6:0], rx_in};
  assign sampled_bit = hist[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coerce(input logic [PW-1:0] p);
    if (p == 0) return 32;
    if (p < 8) return 8;
    return int'(p);
  endfunction

  // Frame-level reference: time index within the frame, bit index = t / P.
  bit         m_busy = 0, m_pe = 0, m_pt = 0, m_dv = 0, m_perr = 0, m_serr = 0;
  int         m_t = 0, m_P = 8;
  logic [7:0] m_data = 8'h00, m_p_data = 8'h00;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy = 0; m_dv = 0; m_perr = 0; m_serr = 0; m_t = 0; m_p_data = 8'h00;
    end else begin
      m_dv = 0;
      if (!m_busy) begin
        if (!rx_in) begin
          m_busy = 1; m_t = 0; m_P = coerce(prescale);
          m_pe = par_en; m_pt = par_typ; m_perr = 0; m_serr = 0;
        end
      end else begin
        if (m_t % m_P == m_P - 1) begin
          int b;
          b = m_t / m_P;
          if (b == 0) begin
            if (sampled_bit) m_busy = 0;
          end else if (b <= DW) begin
            m_data[b-1] = sampled_bit;
          end else if (m_pe && b == DW + 1) begin
            if (((^m_data) ^ sampled_bit) != m_pt) m_perr = 1;
          end else begin
            m_serr = !sampled_bit;
            if (sampled_bit && !m_perr) begin
              m_p_data = m_data;
              m_dv = 1;
            end
            m_busy = 0;
          end
        end
        m_t++;
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", busy, m_busy);
    chk("dat_samp_en", dat_samp_en, m_busy);
    chk("edge_cnt", edge_cnt, m_busy ? m_t % m_P : 0);
    chk("data_valid", data_valid, m_dv);
    chk("p_data", p_data, m_p_data);
    chk("par_err", par_err, m_perr);
    chk("stp_err", stp_err, m_serr);
  end

  // Scoreboard of words the stimulus expects to be delivered, plus run-length
  // of the most recent busy interval.
  logic [7:0] exp_q[$];
  int dv_cnt = 0, run = 0, last_run = 0;
  always @(negedge CLK) begin
    if (RST && data_valid) begin
      dv_cnt++;
      chk("dv_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("dv_word", p_data, exp_q.pop_front());
    end
    if (busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic drive_line(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [PW-1:0] p_in, input bit pe, input bit pt,
                            input logic [7:0] d, input bit bad_par, input bit stop_bit,
                            input int gap);
    int P;
    logic pbit;
    P = coerce(p_in);
    pbit = (^d) ^ pt ^ bad_par;
    if (stop_bit && !(pe && bad_par)) exp_q.push_back(d);
    prescale = p_in; par_en = pe; par_typ = pt;
    drive_line(1'b0, P);
    for (int i = 0; i < 8; i++) drive_line(d[i], P);
    if (pe) drive_line(pbit, P);
    drive_line(stop_bit, P);
    if (gap > 0) drive_line(1'b1, gap);
  endtask

  initial begin
    int dv0;
    logic [7:0] rd;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_flags", {data_valid, par_err, stp_err, edge_cnt}, 0);
    RST = 1'b1;
    drive_line(1'b1, 4);

    // 8N1 at 16x
    dv0 = dv_cnt;
    send_frame(5'd16, 0, 0, 8'hA5, 0, 1, 4);
    chk("a5_dv_count", dv_cnt - dv0, 1);
    chk("a5_p_data", p_data, 8'hA5);
    chk("a5_busy_len", last_run, 160);
    chk("a5_errs", {par_err, stp_err}, 0);

    // Even parity at 8x, correct then corrupted
    send_frame(5'd8, 1, 0, 8'h3C, 0, 1, 4);
    chk("3c_p_data", p_data, 8'h3C);
    chk("3c_par_err", par_err, 0);
    chk("3c_busy_len", last_run, 88);
    dv0 = dv_cnt;
    send_frame(5'd8, 1, 0, 8'h3C ^ 8'h00, 1, 1, 4);
    chk("3c_bad_par_err", par_err, 1);
    chk("3c_bad_no_dv", dv_cnt - dv0, 0);
    chk("3c_bad_p_data_held", p_data, 8'h3C);

    // 32x (prescale field 0) with a bad stop bit, then a good frame
    dv0 = dv_cnt;
    send_frame(5'd0, 0, 0, 8'h81, 0, 0, 4);
    chk("81_stp_err", stp_err, 1);
    chk("81_no_dv", dv_cnt - dv0, 0);
    chk("81_busy_len", last_run, 320);
    fork
      send_frame(5'd0, 0, 0, 8'h7E, 0, 1, 4);
      begin
        repeat (3) @(posedge CLK);
        #2;
        chk("7e_flags_clear", {busy, par_err, stp_err}, 3'b100);
      end
    join
    chk("7e_p_data", p_data, 8'h7E);

    // Start glitch at 16x
    dv0 = dv_cnt;
    prescale = 5'd16;
    drive_line(1'b0, 3);
    drive_line(1'b1, 24);
    chk("glitch_busy_len", last_run, 16);
    chk("glitch_no_dv", dv_cnt - dv0, 0);
    chk("glitch_flags", {par_err, stp_err, p_data}, {2'b00, 8'h7E});

    // Prescale change mid-frame
    fork
      send_frame(5'd16, 0, 0, 8'h9D, 0, 1, 4);
      begin
        repeat (40) @(posedge CLK);
        #1 prescale = 5'd8;
      end
    join
    chk("pchg_busy_len", last_run, 160);
    chk("pchg_p_data", p_data, 8'h9D);
    send_frame(5'd8, 0, 0, 8'h42, 0, 1, 4);
    chk("pchg_next_len", last_run, 80);

    // Back-to-back frames with no idle gap
    dv0 = dv_cnt;
    send_frame(5'd8, 0, 0, 8'h12, 0, 1, 0);
    send_frame(5'd8, 1, 1, 8'h34, 0, 1, 0);
    send_frame(5'd8, 0, 0, 8'h56, 0, 1, 4);
    chk("b2b_dv_count", dv_cnt - dv0, 3);
    chk("b2b_p_data", p_data, 8'h56);

    // Reset in the middle of data bit 4
    rd = 8'hC3;
    prescale = 5'd16; par_en = 0;
    drive_line(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_line(rd[i], 16);
    drive_line(rd[4], 8);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, dat_samp_en, edge_cnt, data_valid, par_err, stp_err}, 0);
    chk("rst_mid_p_data", p_data, 0);
    rx_in = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    drive_line(1'b1, 4);
    send_frame(5'd16, 0, 0, 8'h55, 0, 1, 4);
    chk("post_rst_55", p_data, 8'h55);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [PW-1:0] p;
      sel = $urandom_range(0, 3);
      p = (sel == 0) ? 5'd8 : (sel == 1) ? 5'd16 : (sel == 2) ? 5'd0 : 5'd3;
      send_frame(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) != 0), $urandom_range(1, 4));
    end
    drive_line(1'b1, 8);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
